multiflux_delay_line: RTL and testbench

//  Per-channel N-sample delay actor for FLUX interleaved pel streams.

---
 rtl/multiflux_delay_line_pkg.sv | 24 ++
 rtl/multiflux_delay_line_if.sv | 28 ++
 rtl/multiflux_delay_line_rr_arbiter_mf.sv | 45 ++++
 rtl/multiflux_delay_line.sv | 104 ++++++++++
 tb/tb_multiflux_delay_line.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/multiflux_delay_line_pkg.sv
// Shared helpers for the multi-flux delay line.
//   tag_w(flux)    : width of the channel tag carried in the FIFO word
//   ptr_w(depth)   : width of a per-channel ring pointer (at least 1 bit)
//   prime_w(depth) : width of a per-channel prime counter counting 0..depth
// Used by multiflux_delay_line and rr_arbiter_mf. The priming feature is
// compiled in by the DELAY_LINE_PRIME_EN macro (see the top-level file).
package multiflux_delay_pkg;

    // Width quantities returned by the helpers below.
    typedef int width_t;

    function automatic width_t tag_w(input width_t flux);
        return $clog2(flux);
    endfunction

    function automatic width_t ptr_w(input width_t depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic width_t prime_w(input width_t depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/multiflux_delay_line_if.sv
// FIFO-side interfaces of the delay-line actor.
//   write_interface : output FIFO. full[FLUX] per channel, write strobe, din = {tag, data}.
//   read_interface  : input FIFO (first-word-fall-through). empty[FLUX], read[FLUX] one-hot,
//                     dout = head word of the channel whose read bit is high.
// Modport actor is the delay-line side, modport fifo the FIFO side.
interface write_interface #(
    parameter int FLUX  = 2,
    parameter int WIDTH = 9
);
    logic [FLUX-1:0]  full;
    logic             write;
    logic [WIDTH-1:0] din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface

interface read_interface #(
    parameter int FLUX  = 2,
    parameter int WIDTH = 9
);
    logic [FLUX-1:0]  empty;
    logic [FLUX-1:0]  read;
    logic [WIDTH-1:0] dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

// File: rtl/multiflux_delay_line_rr_arbiter_mf.sv
// Round-robin arbiter over FLUX requesters.
//   clk, rst  : clock / asynchronous active-high reset
//   req       : per-channel request
//   advance   : a grant was consumed this cycle; last_grant moves to gnt_idx
//   gnt_idx   : combinational grant, nearest requester after last_grant (wrapping)
//   gnt_valid : any requester present
// After reset last_grant = FLUX-1, so channel 0 has first priority.
module rr_arbiter_mf
    import multiflux_delay_pkg::*;
#(
    parameter int FLUX = 2,
    parameter int IW   = tag_w(FLUX)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FLUX-1:0] req,
    input  logic            advance,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);
    logic [IW-1:0] last_grant;

    // Walk offsets from farthest to nearest so the last hit, i.e. the
    // nearest requester after last_grant, is the one that sticks.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = FLUX; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % FLUX;
            if (req[idx]) begin
                gnt_idx   = IW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= IW'(FLUX - 1);
        else if (advance && gnt_valid)
            last_grant <= gnt_idx;
    end

endmodule

// File: rtl/multiflux_delay_line.sv
// Per-channel DEPTH-sample delay actor for FLUX interleaved pel streams.
// Each firing on channel c consumes the head token of c and emits the token
// consumed DEPTH firings earlier on c, tagged with c. Zero-cycle combinational
// actor: one firing per cycle, grant chosen round-robin in the same cycle.
//   clk, rst           : clock / asynchronous active-high reset
//   write_port_out_pel : output FIFO (full in; write, din={tag,data} out)
//   read_port_in_pel   : input FWFT FIFO (empty, dout in; read out)
// Optional feature, macro DELAY_LINE_PRIME_EN: the first DEPTH firings of each
// channel only fill the line (write held low), so no leading zeros are emitted.
module multiflux_delay_line
    import multiflux_delay_pkg::*;
#(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = tag_w(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    write_interface.actor write_port_out_pel,
    read_interface.actor  read_port_in_pel
);
    localparam int PW = ptr_w(DEPTH);

    logic [FLUX-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [FLUX-1:0][PW-1:0]                    ptr;
    logic [FLUX-1:0]                            primed;
    logic [FLUX-1:0]                            eligible;
    logic [TAG_WIDTH-1:0]                       gnt_idx;
    logic                                       gnt_valid;
    logic                                       fire;
    logic [PW-1:0]                              cur_ptr;

    // Tag bits of the incoming word carry nothing the actor needs.
    logic unused_dout_tag;
    assign unused_dout_tag = &{1'b0, read_port_in_pel.dout[WIDTH-1:DATA_WIDTH]};

`ifdef DELAY_LINE_PRIME_EN
    localparam int CW = prime_w(DEPTH);
    logic [FLUX-1:0][CW-1:0] prime;

    always_comb begin
        for (int c = 0; c < FLUX; c++)
            primed[c] = (prime[c] == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prime <= '0;
        else if (fire && !primed[gnt_idx])
            prime[gnt_idx] <= prime[gnt_idx] + 1'b1;
    end
`else
    assign primed = '1;
`endif

    // A priming channel writes nothing, so output back-pressure does not apply.
    always_comb begin
        for (int c = 0; c < FLUX; c++)
            eligible[c] = !read_port_in_pel.empty[c] &&
                          (!write_port_out_pel.full[c] || !primed[c]);
    end

    rr_arbiter_mf #(
        .FLUX (FLUX),
        .IW   (TAG_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .advance   (fire),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign fire    = gnt_valid && !rst;
    assign cur_ptr = ptr[gnt_idx];

    always_comb begin
        read_port_in_pel.read    = '0;
        write_port_out_pel.write = 1'b0;
        write_port_out_pel.din   = '0;
        if (fire) begin
            read_port_in_pel.read[gnt_idx] = 1'b1;
            if (primed[gnt_idx]) begin
                write_port_out_pel.write = 1'b1;
                write_port_out_pel.din   = {gnt_idx, mem[gnt_idx][cur_ptr]};
            end
        end
    end

    // The slot just read out is refilled with the consumed token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            ptr <= '0;
        end else if (fire) begin
            mem[gnt_idx][cur_ptr] <= read_port_in_pel.dout[DATA_WIDTH-1:0];
            ptr[gnt_idx]          <= (cur_ptr == PW'(DEPTH - 1)) ? '0 : cur_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_multiflux_delay_line.sv
// Self-checking bench for multiflux_delay_line.
// Instance A (FLUX=2, DEPTH=3, or DEPTH=2 with DELAY_LINE_PRIME_EN) runs
// hand-computed vector tables; instance B (FLUX=4, DEPTH=1) runs random
// empty/full traffic against a per-channel queue model.
module tb_multiflux_delay_line;
    import multiflux_delay_pkg::*;

    localparam int DW = 8;
    localparam int FA = 2;
`ifdef DELAY_LINE_PRIME_EN
    localparam int DA = 2;
`else
    localparam int DA = 3;
`endif
    localparam int WA = DW + 1;
    localparam int FB = 4;
    localparam int DB = 1;
    localparam int WB = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    write_interface #(.FLUX(FA), .WIDTH(WA)) wa ();
    read_interface  #(.FLUX(FA), .WIDTH(WA)) ra ();
    write_interface #(.FLUX(FB), .WIDTH(WB)) wb ();
    read_interface  #(.FLUX(FB), .WIDTH(WB)) rb ();

    multiflux_delay_line #(.FLUX(FA), .DATA_WIDTH(DW), .DEPTH(DA)) dut_a (
        .clk(clk), .rst(rst), .write_port_out_pel(wa), .read_port_in_pel(ra));
    multiflux_delay_line #(.FLUX(FB), .DATA_WIDTH(DW), .DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .write_port_out_pel(wb), .read_port_in_pel(rb));

    // FWFT sources: dout shows the head of whichever channel is being read.
    logic [DW-1:0] head_a [FA];
    logic [DW-1:0] head_b [FB];

    always_comb begin
        ra.dout = '0;
        for (int c = 0; c < FA; c++) if (ra.read[c]) ra.dout = WA'(head_a[c]);
    end
    always_comb begin
        rb.dout = '0;
        for (int c = 0; c < FB; c++) if (rb.read[c]) rb.dout = WB'(head_b[c]);
    end

    typedef struct packed {
        logic       pre_rst;
        logic [1:0] empty;
        logic [1:0] full;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] rd;
        logic       wr;
        logic [8:0] din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pr, input logic [1:0] e, input logic [1:0] f,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] rd, input logic wr, input logic [8:0] din);
        vec_t v;
        v.pre_rst = pr; v.empty = e; v.full = f; v.d0 = d0; v.d1 = d1;
        v.rd = rd; v.wr = wr; v.din = din;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 (or time 0); returns at posedge+1 with rst low.
    task automatic do_reset();
        rst = 1'b1;
        ra.empty = '0; wa.full = '0; rb.empty = '0; wb.full = '0;
        for (int c = 0; c < FA; c++) head_a[c] = 8'h55;
        for (int c = 0; c < FB; c++) head_b[c] = 8'h55;
        #2;
        chk("rst a read",  32'(ra.read),  32'h0);
        chk("rst a write", 32'(wa.write), 32'h0);
        chk("rst a din",   32'(wa.din),   32'h0);
        chk("rst b read",  32'(rb.read),  32'h0);
        chk("rst b write", 32'(wb.write), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ra.empty = '1; rb.empty = '1;
    endtask

    task automatic apply_a(input vec_t v, input int idx);
        if (v.pre_rst) do_reset();
        ra.empty = v.empty; wa.full = v.full;
        head_a[0] = v.d0;   head_a[1] = v.d1;
        @(negedge clk);
        chk($sformatf("v%0d read", idx),  32'(ra.read),  32'(v.rd));
        chk($sformatf("v%0d write", idx), 32'(wa.write), 32'(v.wr));
        // din is only defined when something is written or nothing fires
        if (v.wr || v.rd == 2'b00)
            chk($sformatf("v%0d din", idx), 32'(wa.din), 32'(v.din));
        @(posedge clk); #1;
    endtask

    // Reference model for B: each channel is a FIFO of stored samples. Without
    // priming it starts holding DEPTH zeros; with priming it starts empty and
    // a firing only writes once more than DEPTH samples have been seen.
    logic [DW-1:0] hq [FB][$];
    int lg_m;

    task automatic run_random(input int ncyc);
        do_reset();
        lg_m = FB - 1;
        for (int c = 0; c < FB; c++) begin
            hq[c].delete();
`ifndef DELAY_LINE_PRIME_EN
            for (int k = 0; k < DB; k++) hq[c].push_back('0);
`endif
            head_b[c] = 8'($urandom);
        end
        for (int n = 0; n < ncyc; n++) begin
            logic [FB-1:0] e, f, elig, exp_rd;
            logic [DW-1:0] exp_d;
            logic exp_w;
            int g;
            e = 4'($urandom) & 4'($urandom);
            f = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rb.empty = e; wb.full = f;
            @(negedge clk);
            for (int c = 0; c < FB; c++)
                elig[c] = !e[c] && (!f[c] || hq[c].size() < DB);
            g = -1;
            for (int k = 1; k <= FB; k++)
                if (g < 0 && elig[(lg_m + k) % FB]) g = (lg_m + k) % FB;
            chk("rand onehot", 32'($countones(rb.read) <= 1), 32'h1);
            if (g < 0) begin
                chk("rand idle read",  32'(rb.read),  32'h0);
                chk("rand idle write", 32'(wb.write), 32'h0);
                chk("rand idle din",   32'(wb.din),   32'h0);
            end else begin
                exp_rd = '0; exp_rd[g] = 1'b1;
                hq[g].push_back(head_b[g]);
                exp_w = hq[g].size() > DB;
                exp_d = exp_w ? hq[g].pop_front() : '0;
                chk($sformatf("rand c%0d read", n),  32'(rb.read),  32'(exp_rd));
                chk($sformatf("rand c%0d write", n), 32'(wb.write), 32'(exp_w));
                if (exp_w)
                    chk($sformatf("rand c%0d din", n), 32'(wb.din), 32'(WB'({2'(g), exp_d})));
                lg_m = g;
            end
            @(posedge clk); #1;
            if (g >= 0) head_b[g] = 8'($urandom);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
`ifndef DELAY_LINE_PRIME_EN
        // single channel: three leading zeros, then 10, 11
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'd10, 8'd0, 2'b01, 1, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd11, 8'd0, 2'b01, 1, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd12, 8'd0, 2'b01, 1, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd13, 8'd0, 2'b01, 1, 9'd10));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd14, 8'd0, 2'b01, 1, 9'd11));
        // all empty / all full: nothing fires
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'd0,  8'd0, 2'b00, 0, 9'd0));
        tbl.push_back(mk(0, 2'b00, 2'b11, 8'd99, 8'd98, 2'b00, 0, 9'd0));
        // both ready after reset: alternate 0,1,... starting at ch0
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'hA0, 8'hB0, 2'b01, 1, 9'h000));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA1, 8'hB0, 2'b10, 1, 9'h100));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA1, 8'hB1, 2'b01, 1, 9'h000));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA2, 8'hB1, 2'b10, 1, 9'h100));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA2, 8'hB2, 2'b01, 1, 9'h000));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA3, 8'hB2, 2'b10, 1, 9'h100));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hA3, 8'hB3, 2'b01, 1, 9'h0A0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 8'h00, 8'hB3, 2'b10, 1, 9'h1B0));
        // full[1]: ch0 back-to-back, then ch1 resumes with its old contents
        tbl.push_back(mk(0, 2'b00, 2'b10, 8'hC0, 8'hD0, 2'b01, 1, 9'h0A1));
        tbl.push_back(mk(0, 2'b00, 2'b10, 8'hC1, 8'hD0, 2'b01, 1, 9'h0A2));
        tbl.push_back(mk(0, 2'b00, 2'b10, 8'hC2, 8'hD0, 2'b01, 1, 9'h0A3));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hC3, 8'hD0, 2'b10, 1, 9'h1B1));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'hC3, 8'hD1, 2'b01, 1, 9'h0C0));
        // full[0]: ch1 fires twice, including the wrap from ch1 back to ch1
        tbl.push_back(mk(0, 2'b00, 2'b01, 8'hC4, 8'hD1, 2'b10, 1, 9'h1B2));
        tbl.push_back(mk(0, 2'b00, 2'b01, 8'hC4, 8'hD2, 2'b10, 1, 9'h1B3));
        foreach (tbl[i]) apply_a(tbl[i], i);

        // async reset mid-stream after five ch0 tokens
        do_reset();
        for (int i = 1; i <= 5; i++)
            apply_a(mk(0, 2'b10, 2'b00, 8'(i), 8'h0, 2'b01, 1,
                       (i > DA) ? 9'(i - DA) : 9'h0), 100 + i);
        ra.empty = 2'b10; wa.full = '0; head_a[0] = 8'd6;
        #1;
        chk("t4 read pre-rst", 32'(ra.read), 32'h1);
        rst = 1'b1;
        #1;
        chk("t4 read in rst",  32'(ra.read),  32'h0);
        chk("t4 write in rst", 32'(wa.write), 32'h0);
        chk("t4 din in rst",   32'(wa.din),   32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4 read post",  32'(ra.read),  32'h1);
        chk("t4 write post", 32'(wa.write), 32'h1);
        chk("t4 din post",   32'(wa.din),   32'h0);
        @(posedge clk); #1;
        for (int i = 7; i <= 9; i++)
            apply_a(mk(0, 2'b10, 2'b00, 8'(i), 8'h0, 2'b01, 1,
                       (i == 9) ? 9'd6 : 9'd0), 200 + i);
`else
        // priming with full[0] held: 7, 8 absorbed, 9 stalls, then 7 emerges
        tbl.push_back(mk(1, 2'b10, 2'b01, 8'd7,  8'd0, 2'b01, 0, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b01, 8'd8,  8'd0, 2'b01, 0, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b01, 8'd9,  8'd0, 2'b00, 0, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b01, 8'd9,  8'd0, 2'b00, 0, 9'd0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd9,  8'd0, 2'b01, 1, 9'd7));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'd10, 8'd0, 2'b01, 1, 9'd8));
        foreach (tbl[i]) apply_a(tbl[i], i);
`endif
        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
